rgmii_tx_ddr_ctrl: RTL and testbench
====================================

Name: rgmii_tx_ddr_ctrl

Overview:
- Sequences the d1/d2 inputs of the output DDR flip-flops for an RGMII transmit interface. Those DDR flip-flops are the TXD[3:0], TX_CTL and forwarded-TXC oddr instances.
- Accepts a byte stream with a valid/ready handshake and converts it to DDR nibble pairs.
  - 1G: one byte per clk.
  - 10/100: nibbles stretched over DIV_100/DIV_10 cycles, with a 50%-duty forwarded clock built from half-cycle DDR slots.
- Sits between the MAC TX path and the oddr instances. clk is the 125 MHz TX clock.

Parameters:
- DIV_100, 5, clk cycles per nibble at 100 Mb/s (≥2)
- DIV_10, 50, clk cycles per nibble at 10 Mb/s (≥2)

Ports:
- clk  input  1  TX clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- speed  input  2  2'b10=1G, 2'b01=100M, 2'b00=10M (2'b11 treated as 1G)
- s_tdata  input  8  byte to transmit
- s_tvalid  input  1  byte valid; high = frame in progress (TX_EN)
- s_terror  input  1  TX_ER for this byte
- s_tready  output  1  byte accepted this cycle when s_tvalid & s_tready
- txd_d1  output  4  TXD rising-edge data to oddr d1
- txd_d2  output  4  TXD falling-edge data to oddr d2
- ctl_d1  output  1  TX_CTL rising slot
- ctl_d2  output  1  TX_CTL falling slot
- txc_d1  output  1  forwarded-clock rising slot
- txc_d2  output  1  forwarded-clock falling slot
- active  output  1  frame in progress on the wire
- speed_cur  output  2  currently applied speed

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, except speed_cur = 2'b10. Internal state: cnt=0, phase=0, state=IDLE.
- First cycle after rst deasserts: speed latched into speed_cur.
- States:
  - IDLE→ACTIVE: when a byte is accepted.
  - ACTIVE→IDLE: at a load point where s_tvalid=0.
- Speed latch: speed_cur updates from the speed port only at a load point with state=IDLE and no byte accepted. A change mid-frame is deferred until the frame ends. When speed_cur changes, cnt and phase reset to 0.
- 1G (speed_cur=10):
  - Every cycle is a load point; s_tready=1 constantly.
  - Latency 1 cycle: txd_d1=s_tdata[3:0], txd_d2=s_tdata[7:4], ctl_d1=s_tvalid, ctl_d2=s_tvalid^s_terror.
  - If s_tvalid=0: txd_d1/txd_d2 = 0, ctl_d1/ctl_d2 = 0.
  - txc_d1=1, txc_d2=0.
- 10/100, with DIV = DIV_100 or DIV_10:
  - cnt counts 0..DIV-1 and wraps. phase toggles on each wrap.
  - Load point: cnt==DIV-1 and phase==1. s_tready is high only at a load point, so it is a 1-cycle pulse every 2*DIV cycles.
  - An accepted byte is captured into a holding register.
  - From the next cycle (cnt=0, phase=0), for DIV cycles: txd_d1=txd_d2=low nibble. For the following DIV cycles (phase=1): high nibble.
  - ctl_d1=s_tvalid and ctl_d2=s_tvalid^s_terror, both captured at the load point and held for 2*DIV cycles.
  - No byte accepted at a load point: txd=0, ctl=0 for the next 2*DIV cycles.
  - Forwarded clock: half-slot index h=2*cnt for d1 and 2*cnt+1 for d2. Slot is 1 iff h<DIV. Gives exact 50% duty for odd DIV; e.g. DIV=5 gives d1/d2 = 11,11,10,00,00.
  - Nibble changes align with the TXC rising edge. Any required TXC delay is external.
- Latency from load point to first nibble: 1 cycle. First-byte wait from s_tvalid rising: ≤2*DIV cycles.
- Underrun mid-frame (s_tvalid=0 at a load point): frame ends, ctl→0, state→IDLE. No error is inserted.
- rst mid-frame: outputs go to their reset values the next cycle. The byte in flight is dropped.

Test Plan:
- 1G: speed=10; bytes 0xA5,0x3C,0xFF with valid, then valid=0 → 1 cycle later txd_d1/txd_d2 = 5/A, C/3, F/F. ctl_d1/ctl_d2 = 11 ×3, then 00. s_tready constantly 1. txc_d1/txc_d2 = 1/0.
- 100M, DIV_100=5: reset, speed=01, byte 0x5A held valid → s_tready pulses at cnt=4/phase=1. Next 5 cycles txd_d1/txd_d2 = A; next 5 cycles = 5. txc per cycle = 11,11,10,00,00 repeating.
- 10M, DIV_10=50: byte 0x81 with s_terror=1 → ctl_d1/ctl_d2 = 1/0 held 100 cycles. txd=1 for 50 cycles then 8 for 50. txc high for cnt<25.
- Speed change mid-frame: 1G frame in progress, speed→01 → speed_cur stays 10 until the first valid=0 cycle, then 01. cnt restarts at 0.
- Underrun at 100M: valid dropped before second load point → ctl=0 from next cycle, active=0, speed relatches.
- rst during a 10M frame → next cycle all outputs 0, speed_cur=10. Following cycle speed_cur=port value.

Source files
------------

// File: rtl/rgmii_tx_ddr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rgmii_tx_ddr_ctrl_if
//  Purpose  : Byte-stream valid/ready handshake feeding the RGMII TX sequencer
//  Revision : 1.0 - initial release
// ============================================================================
interface rgmii_tx_ddr_ctrl_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_terror;
    logic       s_tready;

    modport master (output s_tdata, output s_tvalid, output s_terror, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, input  s_terror, output s_tready);
endinterface
`default_nettype wire

// File: rtl/rgmii_tx_ddr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rgmii_tx_ddr_ctrl
//  Purpose  : Drives d1/d2 of the RGMII TXD/TX_CTL/TXC oddr cells at 1G/100M/10M
//  Revision : 1.0 - initial release
// ============================================================================
module rgmii_tx_ddr_ctrl #(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [1:0]       speed,
    rgmii_tx_ddr_ctrl_if.slave    tx,
    output logic [3:0]            txd_d1,
    output logic [3:0]            txd_d2,
    output logic                  ctl_d1,
    output logic                  ctl_d2,
    output logic                  txc_d1,
    output logic                  txc_d2,
    output logic                  active,
    output logic [1:0]            speed_cur
);

    localparam int c_div_max = (DIV_100 > DIV_10) ? DIV_100 : DIV_10;
    localparam int c_cnt_w   = $clog2(c_div_max + 1);
    localparam logic [c_cnt_w-1:0] c_div100 = c_cnt_w'(DIV_100);
    localparam logic [c_cnt_w-1:0] c_div10  = c_cnt_w'(DIV_10);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam logic [1:0] c_spd_1g  = 2'b10;
    localparam logic [1:0] c_spd_100 = 2'b01;

    localparam logic [0:0] c_idle   = 1'b0;
    localparam logic [0:0] c_active = 1'b1;

    logic [0:0]         r_state;
    logic [1:0]         r_spd;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_phase;
    logic [7:0]         r_hold;
    logic               r_ctl1;
    logic               r_ctl2;
    logic               r_tready;
    logic [3:0]         r_txd_d1;
    logic [3:0]         r_txd_d2;
    logic               r_ctl_d1;
    logic               r_ctl_d2;
    logic               r_txc_d1;
    logic               r_txc_d2;

    logic               w_is1g;
    logic [c_cnt_w-1:0] w_div;
    logic               w_wrap;
    logic               w_load;
    logic               w_acc;
    logic [1:0]         w_spd_req;
    logic [1:0]         w_spd_nxt;
    logic               w_spd_chg;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_phase_nxt;
    logic [7:0]         w_hold_nxt;
    logic               w_ctl1_nxt;
    logic               w_ctl2_nxt;
    logic [0:0]         w_state_nxt;
    logic               w_is1g_nxt;
    logic [c_cnt_w-1:0] w_div_nxt;
    logic               w_tready_nxt;
    logic [3:0]         w_nib;
    logic [3:0]         w_txd1_nxt;
    logic [3:0]         w_txd2_nxt;
    logic               w_txc1_nxt;
    logic               w_txc2_nxt;

    always_comb begin
        w_is1g    = r_spd[1];
        w_div     = (r_spd == c_spd_100) ? c_div100 : c_div10;
        w_wrap    = (r_cnt == (w_div - c_one));
        // At gigabit every cycle carries a byte; slower rates load once per 2*DIV
        w_load    = w_is1g | (w_wrap & r_phase);
        w_acc     = tx.s_tvalid & r_tready;
        w_spd_req = (speed == 2'b11) ? c_spd_1g : speed;

        w_spd_nxt = r_spd;
        if (w_load && (r_state == c_idle) && !w_acc) begin
            w_spd_nxt = w_spd_req;
        end
        w_spd_chg = (w_spd_nxt != r_spd);

        w_cnt_nxt   = '0;
        w_phase_nxt = 1'b0;
        if (!w_spd_chg && !w_is1g) begin
            w_cnt_nxt   = w_wrap ? '0 : (r_cnt + c_one);
            w_phase_nxt = r_phase ^ w_wrap;
        end

        w_hold_nxt  = r_hold;
        w_ctl1_nxt  = r_ctl1;
        w_ctl2_nxt  = r_ctl2;
        w_state_nxt = r_state;
        if (w_load) begin
            w_hold_nxt  = w_acc ? tx.s_tdata : 8'h00;
            w_ctl1_nxt  = w_acc;
            w_ctl2_nxt  = w_acc & ~tx.s_terror;
            w_state_nxt = w_acc ? c_active : c_idle;
        end

        w_is1g_nxt   = w_spd_nxt[1];
        w_div_nxt    = (w_spd_nxt == c_spd_100) ? c_div100 : c_div10;
        w_tready_nxt = w_is1g_nxt |
                       ((w_cnt_nxt == (w_div_nxt - c_one)) & w_phase_nxt);

        // Each clk spans two half-slots; high while the half-slot index < DIV
        w_nib      = w_phase_nxt ? w_hold_nxt[7:4] : w_hold_nxt[3:0];
        w_txd1_nxt = w_is1g_nxt ? w_hold_nxt[3:0] : w_nib;
        w_txd2_nxt = w_is1g_nxt ? w_hold_nxt[7:4] : w_nib;
        w_txc1_nxt = w_is1g_nxt | ({w_cnt_nxt, 1'b0} < {1'b0, w_div_nxt});
        w_txc2_nxt = ~w_is1g_nxt & ({w_cnt_nxt, 1'b1} < {1'b0, w_div_nxt});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_idle;
            r_spd    <= c_spd_1g;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
            r_hold   <= 8'h00;
            r_ctl1   <= 1'b0;
            r_ctl2   <= 1'b0;
            r_tready <= 1'b0;
            r_txd_d1 <= 4'h0;
            r_txd_d2 <= 4'h0;
            r_ctl_d1 <= 1'b0;
            r_ctl_d2 <= 1'b0;
            r_txc_d1 <= 1'b0;
            r_txc_d2 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_spd    <= w_spd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_phase  <= w_phase_nxt;
            r_hold   <= w_hold_nxt;
            r_ctl1   <= w_ctl1_nxt;
            r_ctl2   <= w_ctl2_nxt;
            r_tready <= w_tready_nxt;
            r_txd_d1 <= w_txd1_nxt;
            r_txd_d2 <= w_txd2_nxt;
            r_ctl_d1 <= w_ctl1_nxt;
            r_ctl_d2 <= w_ctl2_nxt;
            r_txc_d1 <= w_txc1_nxt;
            r_txc_d2 <= w_txc2_nxt;
        end
    end

    assign tx.s_tready = r_tready;
    assign txd_d1      = r_txd_d1;
    assign txd_d2      = r_txd_d2;
    assign ctl_d1      = r_ctl_d1;
    assign ctl_d2      = r_ctl_d2;
    assign txc_d1      = r_txc_d1;
    assign txc_d2      = r_txc_d2;
    assign active      = (r_state == c_active);
    assign speed_cur   = r_spd;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_ddr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgmii_tx_ddr_ctrl
//  Purpose  : Randomized self-checking bench for rgmii_tx_ddr_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgmii_tx_ddr_ctrl;

    localparam int c_d100 = 5;
    localparam int c_d10  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed = 2'b10;
    logic [3:0] txd_d1, txd_d2;
    logic       ctl_d1, ctl_d2, txc_d1, txc_d2, active;
    logic [1:0] speed_cur;

    rgmii_tx_ddr_ctrl_if bus ();

    rgmii_tx_ddr_ctrl #(.DIV_100(c_d100), .DIV_10(c_d10)) dut (
        .clk       (clk),
        .rst       (rst),
        .speed     (speed),
        .tx        (bus),
        .txd_d1    (txd_d1),
        .txd_d2    (txd_d2),
        .ctl_d1    (ctl_d1),
        .ctl_d2    (ctl_d2),
        .txc_d1    (txc_d1),
        .txc_d2    (txc_d2),
        .active    (active),
        .speed_cur (speed_cur)
    );

    always #4 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cycle = 0;
    string step  = "reset";

    // Reference model: wire position p inside the 2*DIV byte window
    bit       m_rs  = 1'b1;
    logic [1:0] m_spd = 2'b10;
    int       m_p   = 0;
    bit       m_act = 1'b0;
    bit       m_has = 1'b0;
    bit       m_acc = 1'b0;
    logic [7:0] m_byte = 8'h00;
    bit       m_err = 1'b0;

    function automatic int divof(input logic [1:0] s);
        return (s == 2'b01) ? c_d100 : c_d10;
    endfunction

    function automatic logic [1:0] norm(input logic [1:0] s);
        return (s == 2'b11) ? 2'b10 : s;
    endfunction

    task automatic model_step();
        bit g, load, was_idle;
        int d;
        if (rst) begin
            m_rs = 1'b1; m_spd = 2'b10; m_p = 0;
            m_act = 1'b0; m_has = 1'b0; m_acc = 1'b0;
        end else begin
            g    = m_spd[1];
            d    = divof(m_spd);
            load = g || (m_p == 2 * d - 1);
            m_acc = bus.s_tvalid && load && !m_rs;
            if (load) begin
                was_idle = !m_act;
                m_has  = m_acc;
                m_byte = bus.s_tdata;
                m_err  = bus.s_terror;
                m_act  = m_acc;
                if (was_idle && !m_acc && norm(speed) != m_spd) begin
                    m_spd = norm(speed);
                    m_p   = 0;
                end else begin
                    m_p = g ? 0 : (m_p + 1) % (2 * d);
                end
            end else begin
                m_p = (m_p + 1) % (2 * d);
            end
            m_rs = 1'b0;
        end
    endtask

    // {txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2, active, speed_cur, s_tready}
    function automatic logic [15:0] expect_vec();
        bit g;
        int d, k;
        logic [3:0] e1, e2, nib;
        logic c1, c2, k1, k2, rdy;
        if (m_rs) return {4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        g   = m_spd[1];
        d   = divof(m_spd);
        k   = g ? 0 : (m_p % d);
        k1  = g ? 1'b1 : ((2 * k) < d);
        k2  = g ? 1'b0 : ((2 * k + 1) < d);
        rdy = g ? 1'b1 : (m_p == 2 * d - 1);
        e1 = 4'h0; e2 = 4'h0; c1 = 1'b0; c2 = 1'b0;
        if (m_has) begin
            if (g) begin
                e1 = m_byte[3:0]; e2 = m_byte[7:4];
            end else begin
                nib = (m_p < d) ? m_byte[3:0] : m_byte[7:4];
                e1 = nib; e2 = nib;
            end
            c1 = 1'b1;
            c2 = !m_err;
        end
        return {e1, e2, c1, c2, k1, k2, m_act, m_spd, rdy};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        cycle++;
        check(step, {txd_d1, txd_d2, ctl_d1, ctl_d2, txc_d1, txc_d2, active, speed_cur, bus.s_tready},
              expect_vec());
    endtask

    task automatic send_byte(input logic [7:0] b, input bit e);
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = b;
        bus.s_terror = e;
        for (int i = 0; i < 4 * c_d10; i++) begin
            cyc();
            if (m_acc) break;
        end
    endtask

    task automatic idle(input int n);
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h00;
        bus.s_terror = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic rand_frame(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h00;
        bus.s_terror = 1'b0;

        repeat (3) cyc();
        rst = 1'b0;
        step = "idle_1g";
        idle(3);

        step = "frame_1g";
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        idle(3);
        rand_frame(16);
        idle(2);

        step = "speed_change_midframe";
        rand_frame(3);
        speed = 2'b01;
        rand_frame(3);
        idle(20);

        step = "frame_100m";
        send_byte(8'h5A, 1'b0);
        rand_frame(3);
        idle(25);

        step = "underrun_100m";
        rand_frame(1);
        speed = 2'b00;
        idle(30);

        step = "frame_10m";
        send_byte(8'h81, 1'b1);
        rand_frame(1);
        idle(120);

        step = "reset_midframe_10m";
        send_byte(8'($urandom), 1'b0);
        bus.s_tdata = 8'($urandom);
        repeat (30) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle(6);

        step = "random_speeds";
        for (int r = 0; r < 6; r++) begin
            speed = 2'($urandom);
            idle(110);
            rand_frame($urandom_range(2, 5));
            idle($urandom_range(1, 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
